// File: rtl/apb_mailbox_if.sv
// APB bus bundle for the mailbox slave: request signals from the master,
// plus the completion, read data and error signals returned by the slave.
interface apb_mailbox_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic              pready;
    logic [DATA_W-1:0] prdata;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_mailbox.sv
// APB-slave mailbox: NUM_CH FIFO channels with DATA/STATUS/CTRL registers,
// programmable wait states, protocol-error reporting and per-channel level IRQs.
module apb_mailbox #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 12,
    parameter int NUM_CH      = 4,
    parameter int DEPTH       = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic              pclk,
    input  logic              preset,
    apb_mailbox_if.slave      bus,
    output logic [NUM_CH-1:0] irq
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(NUM_CH * 16);
    localparam logic [2:0]      WAIT_INIT  = 3'(WAIT_STATES);

    typedef enum logic [1:0] {
        OFF_DATA   = 2'd0,
        OFF_STATUS = 2'd1,
        OFF_CTRL   = 2'd2,
        OFF_RSVD   = 2'd3
    } offset_e;

    logic [2:0]        wait_cnt_r;
    logic [DATA_W-1:0] mem_r    [NUM_CH][DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r [NUM_CH];
    logic [PTR_W-1:0]  rd_ptr_r [NUM_CH];
    logic [CNT_W-1:0]  cnt_r    [NUM_CH];
    logic [NUM_CH-1:0] irq_en_r;
    logic [NUM_CH-1:0] irq_r;
    logic [NUM_CH-1:0] empty_s;
    logic [NUM_CH-1:0] full_s;

    offset_e           off_s;
    logic [CH_W-1:0]   ch_s;
    logic              access_s;
    logic              pready_s;
    logic              addr_err_s;
    logic              op_err_s;
    logic              err_s;
    logic              commit_s;
    logic              push_s;
    logic              pop_s;
    logic              ctrl_wr_s;
    logic              sel_empty_s;
    logic              sel_full_s;
    logic [DATA_W-1:0] status_s;
    logic [DATA_W-1:0] ctrl_s;
    logic [DATA_W-1:0] rdata_s;

    // Per-channel empty/full flags derived from the occupancy counters
    always_comb begin
        empty_s = '0;
        full_s  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            empty_s[c] = (cnt_r[c] == CNT_W'(0));
            full_s[c]  = (cnt_r[c] == CNT_W'(DEPTH));
        end
    end

    // Address decode, error classification and commit strobes
    always_comb begin
        ch_s        = bus.paddr[4 +: CH_W];
        off_s       = offset_e'(bus.paddr[3:2]);
        access_s    = bus.psel & bus.penable;
        // Reset is folded in so an in-flight transfer dies the instant preset rises
        pready_s    = access_s & (wait_cnt_r == 3'd0) & ~preset;
        addr_err_s  = ({1'b0, bus.paddr} >= ADDR_LIMIT) | (bus.paddr[1:0] != 2'b00);
        sel_empty_s = empty_s[ch_s];
        sel_full_s  = full_s[ch_s];
        case (off_s)
            OFF_DATA:   op_err_s = bus.pwrite ? sel_full_s : sel_empty_s;
            OFF_STATUS: op_err_s = bus.pwrite;
            OFF_CTRL:   op_err_s = 1'b0;
            default:    op_err_s = 1'b1;
        endcase
        err_s     = addr_err_s | op_err_s;
        commit_s  = pready_s & ~err_s;
        push_s    = commit_s &  bus.pwrite & (off_s == OFF_DATA);
        pop_s     = commit_s & ~bus.pwrite & (off_s == OFF_DATA);
        ctrl_wr_s = commit_s &  bus.pwrite & (off_s == OFF_CTRL);
    end

    // Read-data mux and bus response; prdata/pslverr are zero outside pready
    always_comb begin
        status_s              = '0;
        status_s[0]           = sel_empty_s;
        status_s[1]           = sel_full_s;
        status_s[8 +: CNT_W]  = cnt_r[ch_s];
        ctrl_s                = '0;
        ctrl_s[0]             = irq_en_r[ch_s];
        case (off_s)
            OFF_DATA:   rdata_s = mem_r[ch_s][rd_ptr_r[ch_s]];
            OFF_STATUS: rdata_s = status_s;
            OFF_CTRL:   rdata_s = ctrl_s;
            default:    rdata_s = '0;
        endcase
        if (commit_s & ~bus.pwrite) begin
            bus.prdata = rdata_s;
        end else begin
            bus.prdata = '0;
        end
        bus.pready  = pready_s;
        bus.pslverr = pready_s & err_s;
    end

    // Wait-state counter: loaded in setup, counts down through the access phase
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            wait_cnt_r <= 3'd0;
        end else if (bus.psel & ~bus.penable) begin
            wait_cnt_r <= WAIT_INIT;
        end else if (access_s && (wait_cnt_r != 3'd0)) begin
            wait_cnt_r <= wait_cnt_r - 3'd1;
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // FIFO pointers, counts, CTRL bits and registered interrupt lines
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wr_ptr_r[c] <= PTR_W'(0);
                rd_ptr_r[c] <= PTR_W'(0);
                cnt_r[c]    <= CNT_W'(0);
            end
            irq_en_r <= '0;
            irq_r    <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (ctrl_wr_s && (ch_s == CH_W'(c))) begin
                    irq_en_r[c] <= bus.pwdata[0];
                    if (bus.pwdata[1]) begin
                        wr_ptr_r[c] <= PTR_W'(0);
                        rd_ptr_r[c] <= PTR_W'(0);
                        cnt_r[c]    <= CNT_W'(0);
                    end
                end else if (push_s && (ch_s == CH_W'(c))) begin
                    wr_ptr_r[c] <= wr_ptr_r[c] + PTR_W'(1);
                    cnt_r[c]    <= cnt_r[c] + CNT_W'(1);
                end else if (pop_s && (ch_s == CH_W'(c))) begin
                    rd_ptr_r[c] <= rd_ptr_r[c] + PTR_W'(1);
                    cnt_r[c]    <= cnt_r[c] - CNT_W'(1);
                end
            end
            irq_r <= irq_en_r & ~empty_s;
        end
    end

    // FIFO storage; contents are intentionally left untouched by reset and flush
    always_ff @(posedge pclk) begin
        if (push_s) begin
            mem_r[ch_s][wr_ptr_r[ch_s]] <= bus.pwdata;
        end
    end

    assign irq = irq_r;

endmodule

// File: tb/tb_apb_mailbox.sv
// Bench for apb_mailbox: a zero-wait instance runs the register/FIFO vector
// table, a three-wait-state instance covers stretched transfers and async reset.
module tb_apb_mailbox;
    localparam int AW  = 12;
    localparam int DW  = 32;
    localparam int NCH = 4;

    typedef struct {
        logic        wr;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    typedef struct {
        logic        wr;
        logic [31:0] rdata;
        logic        err;
        int          waits;
    } exp_t;

    logic           pclk = 1'b0;
    logic           preset0, preset3;
    logic           psel, penable, pwrite, use3;
    logic [AW-1:0]  paddr;
    logic [DW-1:0]  pwdata;
    logic [NCH-1:0] irq0, irq3;
    logic           cur_pready, cur_pslverr;
    logic [DW-1:0]  cur_prdata;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 pclk = ~pclk;

    apb_mailbox_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
    apb_mailbox_if #(.ADDR_W(AW), .DATA_W(DW)) bus3 ();

    assign bus0.psel    = psel & ~use3;
    assign bus0.penable = penable;
    assign bus0.pwrite  = pwrite;
    assign bus0.paddr   = paddr;
    assign bus0.pwdata  = pwdata;
    assign bus3.psel    = psel & use3;
    assign bus3.penable = penable;
    assign bus3.pwrite  = pwrite;
    assign bus3.paddr   = paddr;
    assign bus3.pwdata  = pwdata;

    assign cur_pready  = use3 ? bus3.pready  : bus0.pready;
    assign cur_pslverr = use3 ? bus3.pslverr : bus0.pslverr;
    assign cur_prdata  = use3 ? bus3.prdata  : bus0.prdata;

    apb_mailbox #(.DATA_W(DW), .ADDR_W(AW), .NUM_CH(NCH), .DEPTH(8), .WAIT_STATES(0)) dut0 (
        .pclk(pclk), .preset(preset0), .bus(bus0), .irq(irq0)
    );

    apb_mailbox #(.DATA_W(DW), .ADDR_W(AW), .NUM_CH(NCH), .DEPTH(8), .WAIT_STATES(3)) dut3 (
        .pclk(pclk), .preset(preset3), .bus(bus3), .irq(irq3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic add(input logic wr, input logic [11:0] addr, input logic [31:0] wd,
                       input logic [31:0] rd, input logic err);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wdata = wd; v.rdata = rd; v.err = err;
        vecs.push_back(v);
    endtask

    // One complete APB transfer on the currently selected instance
    task automatic xfer(input logic wr, input logic [11:0] addr, input logic [31:0] wd,
                        input logic [31:0] rd, input logic err, input string tag);
        exp_t e;
        int   waits;
        bit   done;
        e.wr = wr; e.rdata = rd; e.err = err; e.waits = use3 ? 3 : 0;
        exp_q.push_back(e);
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
        @(posedge pclk); #1;
        penable = 1'b1;
        waits = 0;
        done  = 1'b0;
        for (int i = 0; i < 16 && !done; i++) begin
            @(negedge pclk);
            if (cur_pready) done = 1'b1;
            else waits++;
        end
        e = exp_q.pop_front();
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s timeout: pready never rose, expected after %0d waits", tag, e.waits);
        end else begin
            check({tag, " waits"}, 32'(waits), 32'(e.waits));
            check({tag, " pslverr"}, {31'd0, cur_pslverr}, {31'd0, e.err});
            if (!e.wr) check({tag, " prdata"}, cur_prdata, e.rdata);
        end
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
        @(negedge pclk);
        check({tag, " idle pready"}, {31'd0, cur_pready}, 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 12'h000; pwdata = 32'h0;
        use3 = 1'b0; preset0 = 1'b1; preset3 = 1'b1;
        repeat (3) @(posedge pclk);
        #1; preset0 = 1'b0; preset3 = 1'b0;
        @(negedge pclk);
        check("reset irq0", {28'd0, irq0}, 32'd0);
        check("reset irq3", {28'd0, irq3}, 32'd0);
        check("reset pready0", {31'd0, bus0.pready}, 32'd0);
        check("reset pready3", {31'd0, bus3.pready}, 32'd0);

        // Register/FIFO vector table for the zero-wait instance
        add(1'b0, 12'h004, 32'h0, 32'h1, 1'b0);
        for (int i = 0; i < 8; i++) add(1'b1, 12'h000, 32'hA0 + 32'(i), 32'h0, 1'b0);
        add(1'b0, 12'h004, 32'h0, 32'h802, 1'b0);
        for (int i = 0; i < 3; i++) add(1'b0, 12'h000, 32'h0, 32'hA0 + 32'(i), 1'b0);
        for (int i = 0; i < 3; i++) add(1'b1, 12'h000, 32'hB0 + 32'(i), 32'h0, 1'b0);
        add(1'b0, 12'h004, 32'h0, 32'h802, 1'b0);
        for (int i = 0; i < 5; i++) add(1'b0, 12'h000, 32'h0, 32'hA3 + 32'(i), 1'b0);
        for (int i = 0; i < 3; i++) add(1'b0, 12'h000, 32'h0, 32'hB0 + 32'(i), 1'b0);
        add(1'b0, 12'h004, 32'h0, 32'h1, 1'b0);
        for (int i = 0; i < 8; i++) add(1'b1, 12'h010, 32'h100 + 32'(i), 32'h0, 1'b0);
        add(1'b1, 12'h010, 32'hDEAD, 32'h0, 1'b1);
        add(1'b0, 12'h014, 32'h0, 32'h802, 1'b0);
        add(1'b0, 12'h010, 32'h0, 32'h100, 1'b0);
        add(1'b0, 12'h014, 32'h0, 32'h700, 1'b0);
        add(1'b0, 12'h020, 32'h0, 32'h0, 1'b1);
        add(1'b0, 12'h040, 32'h0, 32'h0, 1'b1);
        add(1'b0, 12'h00C, 32'h0, 32'h0, 1'b1);
        add(1'b0, 12'h002, 32'h0, 32'h0, 1'b1);
        add(1'b1, 12'h001, 32'h99, 32'h0, 1'b1);
        add(1'b1, 12'h004, 32'h55, 32'h0, 1'b1);
        add(1'b0, 12'h004, 32'h0, 32'h1, 1'b0);

        foreach (vecs[i]) begin
            xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].err,
                 $sformatf("vec%0d", i));
        end

        // Interrupt enable, level IRQ and flush on channel 3
        xfer(1'b1, 12'h038, 32'h1, 32'h0, 1'b0, "ctrl_en");
        xfer(1'b1, 12'h030, 32'h77, 32'h0, 1'b0, "irq_push");
        repeat (2) @(negedge pclk);
        check("irq after push", {28'd0, irq0}, 32'h8);
        xfer(1'b1, 12'h038, 32'h3, 32'h0, 1'b0, "ctrl_flush");
        repeat (2) @(negedge pclk);
        check("irq after flush", {28'd0, irq0}, 32'h0);
        xfer(1'b0, 12'h034, 32'h0, 32'h1, 1'b0, "status_flushed");
        xfer(1'b0, 12'h038, 32'h0, 32'h1, 1'b0, "ctrl_read");

        // Three-wait-state instance: stretched transfers, then reset mid-transfer
        use3 = 1'b1;
        xfer(1'b1, 12'h000, 32'h11, 32'h0, 1'b0, "ws_push1");
        xfer(1'b0, 12'h004, 32'h0, 32'h100, 1'b0, "ws_status1");
        xfer(1'b1, 12'h000, 32'h22, 32'h0, 1'b0, "ws_push2");
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h000; pwdata = 32'h33;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        preset3 = 1'b1;
        #1;
        check("abort pready now", {31'd0, bus3.pready}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge pclk);
            check($sformatf("abort pready hold%0d", i), {31'd0, bus3.pready}, 32'd0);
        end
        psel = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
        preset3 = 1'b0;
        xfer(1'b0, 12'h004, 32'h0, 32'h1, 1'b0, "ws_status_after_reset");
        check("irq3 after reset", {28'd0, irq3}, 32'h0);
        use3 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
